// File: rtl/pin_owner_ctrl_pkg.sv
// Shared types for the pin ownership controller: FSM states, owner index and
// turnaround counter widths.
package pin_owner_ctrl_pkg;

  // Wide enough for any NumSources up to 255.
  localparam int unsigned SelW = 8;
  localparam int unsigned CntW = 4;

  typedef logic [SelW-1:0] sel_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [0:0] {
    StIdle,
    StBlank
  } state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for bringing asynchronous inputs into the clk_i domain.
module prim_flop_2sync #(
  parameter int unsigned Width = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1_q;
  logic [Width-1:0] stage2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= ResetValue;
      stage2_q <= ResetValue;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/pin_owner_ctrl.sv
// Per-pin ownership mux between several requesters and the padring, with a
// forced tristate gap whenever a pin changes hands.
module pin_owner_ctrl
  import pin_owner_ctrl_pkg::*;
#(
  parameter int unsigned NumberOfPins     = 8,
  parameter int unsigned NumSources       = 2,
  parameter int unsigned TurnaroundCycles = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     cfg_valid_i,
  output logic                                     cfg_ready_o,
  input  logic [$clog2(NumberOfPins)-1:0]          cfg_pin_i,
  input  logic [$clog2(NumSources+1)-1:0]          cfg_src_i,
  output logic                                     cfg_err_o,
  input  logic [NumSources-1:0][NumberOfPins-1:0]  src_out_i,
  input  logic [NumSources-1:0][NumberOfPins-1:0]  src_oe_i,
  output logic [NumberOfPins-1:0]                  src_in_o,
  output logic [NumberOfPins-1:0]                  to_pins_o,
  output logic [NumberOfPins-1:0]                  to_pins_en_o,
  input  logic [NumberOfPins-1:0]                  from_pins_i
);

  localparam int unsigned PinW = $clog2(NumberOfPins);

  state_e          state_q;
  cnt_t            cnt_q;
  logic [PinW-1:0] pin_q;
  sel_t            src_q;
  sel_t            sel_q [NumberOfPins];
  logic            err_q;

  sel_t req_src;
  sel_t cur_owner;
  logic req_bad;
  logic req_same;

  assign req_src = sel_t'(cfg_src_i);
  assign req_bad = (32'(cfg_pin_i) >= NumberOfPins) || (32'(cfg_src_i) > NumSources);

  // Loop lookup keeps the read in range even for unencodable pin indices.
  always_comb begin
    cur_owner = '0;
    for (int p = 0; p < NumberOfPins; p++) begin
      if (PinW'(p) == cfg_pin_i) cur_owner = sel_q[p];
    end
  end

  assign req_same = (req_src == cur_owner);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pin_q   <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
      for (int p = 0; p < NumberOfPins; p++) sel_q[p] <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cfg_valid_i) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else if (!req_same) begin
              state_q <= StBlank;
              pin_q   <= cfg_pin_i;
              src_q   <= req_src;
              cnt_q   <= cnt_t'(TurnaroundCycles - 1);
            end
          end
        end
        StBlank: begin
          if (cnt_q == '0) begin
            for (int p = 0; p < NumberOfPins; p++) begin
              if (PinW'(p) == pin_q) sel_q[p] <= src_q;
            end
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_ready_o = (state_q == StIdle);
  assign cfg_err_o   = err_q;

  always_comb begin
    to_pins_o    = '0;
    to_pins_en_o = '0;
    for (int p = 0; p < NumberOfPins; p++) begin
      for (int s = 0; s < NumSources; s++) begin
        if (sel_q[p] == sel_t'(s + 1)) begin
          to_pins_o[p]    = src_out_i[s][p];
          to_pins_en_o[p] = src_oe_i[s][p];
        end
      end
      if ((state_q == StBlank) && (pin_q == PinW'(p))) to_pins_en_o[p] = 1'b0;
    end
  end

  prim_flop_2sync #(
    .Width      (NumberOfPins),
    .ResetValue ('0)
  ) u_in_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (from_pins_i),
    .q_o    (src_in_o)
  );

endmodule

// File: tb/tb_pin_owner_ctrl.sv
// Directed bench for pin_owner_ctrl: ownership changes, turnaround blanking,
// rejected requests, input synchroniser and reset during blanking.
module tb_pin_owner_ctrl;

  logic            clk;
  logic            rst_ni;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2:0]      cfg_pin;
  logic [1:0]      cfg_src;
  logic            cfg_err;
  logic [1:0][7:0] src_out;
  logic [1:0][7:0] src_oe;
  logic [7:0]      src_in;
  logic [7:0]      to_pins;
  logic [7:0]      to_pins_en;
  logic [7:0]      from_pins;

  int checks;
  int failures;

  pin_owner_ctrl #(
    .NumberOfPins     (8),
    .NumSources       (2),
    .TurnaroundCycles (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_pin_i    (cfg_pin),
    .cfg_src_i    (cfg_src),
    .cfg_err_o    (cfg_err),
    .src_out_i    (src_out),
    .src_oe_i     (src_oe),
    .src_in_o     (src_in),
    .to_pins_o    (to_pins),
    .to_pins_en_o (to_pins_en),
    .from_pins_i  (from_pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge while idle; returns at the negedge one cycle after acceptance.
  task automatic send(input logic [2:0] pin, input logic [1:0] src);
    cfg_pin   = pin;
    cfg_src   = src;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    cfg_valid = 1'b0;
    cfg_pin   = '0;
    cfg_src   = '0;
    src_out   = '{8'h00, 8'hFF};
    src_oe    = '{8'hFF, 8'hFF};
    from_pins = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if (to_pins_en !== 8'h00) begin
      failures++; $display("FAIL reset_en got=%h exp=00", to_pins_en);
    end
    checks++;
    if (to_pins !== 8'h00) begin
      failures++; $display("FAIL reset_out got=%h exp=00", to_pins);
    end
    checks++;
    if (src_in !== 8'h00) begin
      failures++; $display("FAIL reset_src_in got=%h exp=00", src_in);
    end
    checks++;
    if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
      failures++; $display("FAIL reset_cfg got=%b%b exp=10", cfg_ready, cfg_err);
    end
    from_pins = 8'h00;
    rst_ni    = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_assign();
    send(3'd3, 2'd1);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (to_pins_en[3] !== 1'b0 || cfg_ready !== 1'b0) begin
        failures++;
        $display("FAIL assign_blank c%0d got en=%b rdy=%b exp en=0 rdy=0", c, to_pins_en[3], cfg_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (to_pins_en !== 8'h08 || to_pins[3] !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL assign_done got en=%h out3=%b rdy=%b exp en=08 out3=1 rdy=1",
               to_pins_en, to_pins[3], cfg_ready);
    end
    // Pin 0 to source 1 as well, so a bystander is enabled during later blanking.
    send(3'd0, 2'd1);
    repeat (2) @(negedge clk);
    checks++;
    if (to_pins_en !== 8'h09) begin
      failures++; $display("FAIL assign_pin0 got=%h exp=09", to_pins_en);
    end
  endtask

  task automatic test_change_owner();
    send(3'd3, 2'd2);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (to_pins_en !== 8'h01 || to_pins[3] !== 1'b1 || cfg_ready !== 1'b0) begin
        failures++;
        $display("FAIL change_blank c%0d got en=%h out3=%b rdy=%b exp en=01 out3=1 rdy=0",
                 c, to_pins_en, to_pins[3], cfg_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (to_pins_en !== 8'h09 || to_pins[3] !== 1'b0 || to_pins[0] !== 1'b1) begin
      failures++;
      $display("FAIL change_done got en=%h out=%h exp en=09 out3=0 out0=1", to_pins_en, to_pins);
    end
  endtask

  task automatic test_error();
    // Pin indices of 8 and above cannot be encoded on a 3-bit pin port; probe the source bound.
    send(3'd2, 2'd3);
    checks++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL err_pulse got err=%b rdy=%b exp err=1 rdy=1", cfg_err, cfg_ready);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL err_single got err=%b rdy=%b exp err=0 rdy=1", cfg_err, cfg_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (to_pins_en !== 8'h09 || to_pins !== 8'h01) begin
      failures++; $display("FAIL err_state got en=%h out=%h exp en=09 out=01", to_pins_en, to_pins);
    end
  endtask

  task automatic test_same_owner();
    send(3'd3, 2'd2);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || to_pins_en !== 8'h09) begin
        failures++;
        $display("FAIL same_owner c%0d got rdy=%b err=%b en=%h exp rdy=1 err=0 en=09",
                 c, cfg_ready, cfg_err, to_pins_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sync();
    logic [7:0] vals [2];
    vals[0] = 8'h20;
    vals[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      from_pins = vals[i];
      @(negedge clk);
      checks++;
      if (src_in[5] !== ~vals[i][5]) begin
        failures++; $display("FAIL sync_early t%0d got=%b exp=%b", i, src_in[5], ~vals[i][5]);
      end
      @(negedge clk);
      checks++;
      if (src_in[5] !== vals[i][5]) begin
        failures++; $display("FAIL sync_late t%0d got=%b exp=%b", i, src_in[5], vals[i][5]);
      end
    end
  endtask

  task automatic test_reset_in_blank();
    send(3'd5, 2'd1);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (to_pins_en !== 8'h00 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL rst_blank_during got en=%h rdy=%b exp en=00 rdy=1", to_pins_en, cfg_ready);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (to_pins_en !== 8'h00 || to_pins !== 8'h00 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_blank_after got en=%h out=%h rdy=%b exp en=00 out=00 rdy=1",
               to_pins_en, to_pins, cfg_ready);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_assign();
    test_change_owner();
    test_error();
    test_same_owner();
    test_sync();
    test_reset_in_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
